// File: rtl/stack_core.sv
// LIFO storage engine: storage array, stack pointer, registered top-of-stack
// and sticky overflow/underflow flags driven by single-cycle push/pop strobes.
module stack_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    sp_reg;
    logic [CW-1:0]    sp_next;
    logic [WIDTH-1:0] dout_reg;
    logic [WIDTH-1:0] dout_next;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             overflow_set;
    logic             underflow_set;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    below_addr;
    logic             is_empty;
    logic             is_full;

    assign is_empty   = (sp_reg == '0);
    assign is_full    = (sp_reg == CW'(DEPTH));
    // Entry just under the TOS; only consumed when sp >= 2, so wrap is harmless.
    assign below_addr = sp_reg[AW-1:0] - AW'(2);

    always_comb begin
        sp_next       = sp_reg;
        dout_next     = dout_reg;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = sp_reg[AW-1:0];
        if (push && pop && !is_empty) begin
            // Replace TOS in place; legal even when full.
            mem_we    = 1'b1;
            mem_waddr = sp_reg[AW-1:0] - AW'(1);
            dout_next = din;
        end else if (push) begin
            if (is_full) begin
                overflow_set = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_reg[AW-1:0];
                sp_next   = sp_reg + CW'(1);
                dout_next = din;
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_set = 1'b1;
            end else begin
                sp_next   = sp_reg - CW'(1);
                dout_next = (sp_reg == CW'(1)) ? '0 : mem[below_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_reg        <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (ena) begin
            sp_reg        <= sp_next;
            dout_reg      <= dout_next;
            // Set has priority over a same-cycle clear.
            overflow_reg  <= (overflow_reg & ~clr_err) | overflow_set;
            underflow_reg <= (underflow_reg & ~clr_err) | underflow_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ena && mem_we) begin
            mem[mem_waddr] <= din;
        end
    end

    assign dout      = dout_reg;
    assign count     = sp_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
endmodule

// File: tb/tb_stack_core.sv
// Self-checking bench for stack_core: queue-based reference model compared
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_stack_core;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Reference model: the stack as a queue, TOS at the back.
    logic [WIDTH-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit e_o, e_u;

    stack_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .push(push), .pop(pop),
        .din(din), .clr_err(clr_err), .dout(dout), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (ena) begin
            e_o = 1'b0;
            e_u = 1'b0;
            if (push && pop && q.size() > 0) begin
                q[q.size()-1] = din;
            end else if (push) begin
                if (q.size() == DEPTH) e_o = 1'b1;
                else q.push_back(din);
            end else if (pop) begin
                if (q.size() == 0) e_u = 1'b1;
                else void'(q.pop_back());
            end
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (e_o) m_ovf = 1'b1;
            if (e_u) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_dout", dout, (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
            chk("model_count", count, q.size());
            chk("model_empty", empty, q.size() == 0);
            chk("model_full", full, q.size() == DEPTH);
            chk("model_overflow", overflow, m_ovf);
            chk("model_underflow", underflow, m_unf);
        end
    end

    task automatic drive(input logic p, input logic po, input logic [WIDTH-1:0] d,
                         input logic c, input logic e, input logic r);
        push = p; pop = po; din = d; clr_err = c; ena = e; rst_n = r;
        @(posedge clk);
        #2;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; ena = 1'b1;
        $display("op push=%0b pop=%0b din=0x%02h clr=%0b ena=%0b rst_n=%0b -> dout=0x%02h count=%0d ovf=%0b unf=%0b",
                 p, po, d, c, e, r, dout, count, overflow, underflow);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d); drive(1, 0, d, 0, 1, 1); endtask
    task automatic do_pop();                          drive(0, 1, 8'h00, 0, 1, 1); endtask
    task automatic do_pp(input logic [WIDTH-1:0] d);   drive(1, 1, d, 0, 1, 1); endtask
    task automatic idle();                            drive(0, 0, 8'h00, 0, 1, 1); endtask

    initial begin
        // Reset held for two cycles.
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checking = 1'b1;
        drive(0, 0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++) idle();
        chk("reset_dout", dout, 0);
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_unf", underflow, 0);

        // Push then pop in order.
        do_push(8'h11); chk("push1_dout", dout, 8'h11); chk("push1_count", count, 1);
        do_push(8'h22); chk("push2_dout", dout, 8'h22); chk("push2_count", count, 2);
        do_push(8'h33); chk("push3_dout", dout, 8'h33); chk("push3_count", count, 3);
        do_pop(); chk("pop1_dout", dout, 8'h22);
        do_pop(); chk("pop2_dout", dout, 8'h11);
        do_pop(); chk("pop3_dout", dout, 0); chk("pop3_empty", empty, 1);

        // Fill and overflow.
        for (int i = 0; i < DEPTH; i++) do_push(8'(i));
        chk("fill_full", full, 1); chk("fill_count", count, 16); chk("fill_dout", dout, 8'h0F);
        do_push(8'hAA);
        chk("ovf_flag", overflow, 1); chk("ovf_dout", dout, 8'h0F); chk("ovf_count", count, 16);
        do_pp(8'hBB);
        chk("full_replace_dout", dout, 8'hBB); chk("full_replace_count", count, 16);
        drive(0, 0, 8'h00, 1, 1, 1);
        chk("ovf_cleared", overflow, 0);

        // Drain, then underflow and clear race.
        for (int i = 0; i < DEPTH; i++) do_pop();
        chk("drain_empty", empty, 1);
        do_pop();
        chk("unf_flag", underflow, 1); chk("unf_count", count, 0); chk("unf_dout", dout, 0);
        drive(0, 1, 8'h00, 1, 1, 1);
        chk("unf_race", underflow, 1);
        drive(0, 0, 8'h00, 1, 1, 1);
        chk("unf_cleared", underflow, 0);

        // Simultaneous push and pop.
        do_push(8'h11); do_push(8'h22);
        do_pp(8'h5A);
        chk("pp_dout", dout, 8'h5A); chk("pp_count", count, 2);
        do_pop(); chk("pp_pop_dout", dout, 8'h11);
        do_pop();
        do_pp(8'h77);
        chk("pp_empty_count", count, 1); chk("pp_empty_dout", dout, 8'h77);
        chk("pp_empty_unf", underflow, 0);

        // Enable gating and reset priority.
        drive(1, 0, 8'h99, 0, 0, 1);
        chk("ena_count", count, 1); chk("ena_dout", dout, 8'h77);
        drive(1, 0, 8'h44, 0, 1, 0);
        chk("rst_count", count, 0); chk("rst_dout", dout, 0);
        do_push(8'h66);
        chk("post_rst_count", count, 1); chk("post_rst_dout", dout, 8'h66);
        idle(); idle();

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stack_core.md
# stack_core

Synchronous LIFO storage engine behind the `tt_um_yannickreiss_stack` top level. The top-level pin wrapper decodes `ui_in`/`uio_in` into push/pop/clear strobes, and this block consumes them. It returns a registered top-of-stack value plus status flags, which the wrapper drives onto `uo_out`/`uio_out`. The block holds all stack state: storage array, stack pointer and sticky error flags.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  block enable. When low, all strobes are ignored and state holds.
- `push`  in  1  push strobe, one cycle per operation.
- `pop`  in  1  pop strobe, one cycle per operation.
- `din`  in  WIDTH  data to push, sampled when `push` is high.
- `clr_err`  in  1  clears the `overflow` and `underflow` flags.
- `dout`  out  WIDTH  registered top-of-stack value. Reads 0 when the stack is empty.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  high when `count == 0`.
- `full`  out  1  high when `count == DEPTH`.
- `overflow`  out  1  sticky: a push was rejected because the stack was full.
- `underflow`  out  1  sticky: a pop was rejected because the stack was empty.

## Operation
- Reset (`rst_n` low at a clock edge):
  - `count`, `dout`, `overflow` and `underflow` go to 0; `empty`=1, `full`=0.
  - Storage contents are don't-care. Reset is not gated by `ena`.
- Stack pointer `sp` equals `count`. The entry at index `sp-1` is the top of stack (TOS).
- All operations below apply only when `ena`=1.
- Push only (`push`=1, `pop`=0):
  - If not full: `mem[sp]`<=`din`, `sp`<=`sp+1`, `dout`<=`din`.
  - If full: state unchanged, `overflow`<=1.
- Pop only (`pop`=1, `push`=0):
  - If `sp`>=2: `sp`<=`sp-1`, `dout`<=`mem[sp-2]`.
  - If `sp`==1: `sp`<=0, `dout`<=0.
  - If empty: state unchanged, `underflow`<=1.
- Push and pop together (replace TOS):
  - If `sp`>=1: `mem[sp-1]`<=`din`, `dout`<=`din`, `sp` unchanged. This is legal when full and does not raise `overflow`.
  - If empty: behaves as push only. No `underflow` is raised.
- No strobe: all state holds.
- `clr_err`=1 clears both sticky flags. If an error occurs in the same cycle, the set wins and the flag is 1 afterwards.
- `empty`, `full` and `count` are derived from registered `sp`. They may be combinational decodes of it, but must not depend on the current-cycle inputs.
- `dout` must always equal the storage entry at `sp-1` (0 when empty). The bench checks this invariant every cycle.

## Timing
- Every operation has 1-cycle latency. Following the edge that samples a strobe, `dout`, `count`, `empty`, `full` and the flags all reflect the result.
- Back-to-back strobes on consecutive cycles are supported at full rate. There is no busy or stall.
- No output path from `push`, `pop` or `din` is combinational.
- If reset is asserted mid-sequence, it takes priority over any strobe in the same cycle. The first post-reset operation sees an empty stack.
- `sp` never wraps: a rejected push at `count`=DEPTH and a rejected pop at `count`=0 leave `sp` untouched.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, release.
  - Required: `dout`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, stable for 5 idle cycles.
- Push then pop in order: push 0x11, 0x22, 0x33.
  - After each push: `dout` = the value just pushed; `count` = 1, 2, 3.
  - Pop three times: `dout` = 0x22, 0x11, then 0 with `empty`=1.
- Fill and overflow (`DEPTH`=16): push 0x00..0x0F, giving `full`=1, `count`=16, `dout`=0x0F.
  - Push 0xAA: `overflow`=1, `dout`=0x0F, `count`=16.
  - Pulse `clr_err`: `overflow`=0.
- Underflow and clear race: from empty, pop once.
  - Required: `underflow`=1, `count`=0, `dout`=0.
  - Next cycle, assert pop and `clr_err` together: `underflow` stays 1.
- Simultaneous push and pop:
  - With TOS 0x22 at `count`=2, apply push+pop with `din`=0x5A: `dout`=0x5A, `count`=2.
  - Pop: `dout`=0x11.
  - From empty, push+pop with `din`=0x77: `count`=1, `dout`=0x77, no `underflow`.
- Enable gating and mid-operation reset:
  - With `ena`=0, push 0x99: no change.
  - With `ena`=1, push 0x44 and assert `rst_n`=0 in the same cycle: `count`=0 and `dout`=0 afterwards.
